// File: rtl/seg_scan_ctrl_if.sv
// Display-load and scan-output bundle for seg_scan_ctrl.
// The master side drives load/value/blanking; the slave side returns decoder and digit drive.
interface seg_scan_ctrl_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  i_load;
   logic [4*DIGITS-1:0]   i_din;
   logic                  i_blz;
   logic [3:0]            o_code;
   logic [DIGITS-1:0]     o_an;
   logic                  o_pend;
   logic                  o_frame;

   modport master (
      output i_load, i_din, i_blz,
      input  o_code, o_an, o_pend, o_frame
   );

   modport slave (
      input  i_load, i_din, i_blz,
      output o_code, o_an, o_pend, o_frame
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered display word, dead-time
// between digits, leading-zero blanking, updates applied only at frame boundaries.
module seg_scan_ctrl #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned DIV    = 50000,
   parameter int unsigned DEAD   = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   seg_scan_ctrl_if.slave  bus
);
   localparam int unsigned CW = $clog2(DIV);
   localparam int unsigned IW = $clog2(DIGITS);
   localparam int unsigned DW = 4 * DIGITS;

   // r_cnt/r_idx hold the slot position that the next edge presents on the outputs
   logic [CW-1:0]     r_cnt;
   logic [IW-1:0]     r_idx;
   logic [DW-1:0]     r_shadow;
   logic [DW-1:0]     r_disp;
   logic              r_pend;
   logic              r_blank;
   logic [3:0]        r_code;
   logic [DIGITS-1:0] r_an;
   logic              r_frame;

   logic              w_bnd;
   logic              w_slot_start;
   logic [DW-1:0]     w_disp_nxt;
   logic              w_hi_zero;
   logic              w_blank;
   logic [3:0]        w_nib;
   logic [DIGITS-1:0] w_an_on;

   // Display word selection at the frame boundary and per-slot decode
   always_comb begin
      w_bnd        = (r_cnt == '0) && (r_idx == '0);
      w_slot_start = (r_cnt == '0);
      w_disp_nxt   = r_disp;
      if (w_bnd && bus.i_load) begin
         w_disp_nxt = bus.i_din;
      end else if (w_bnd && r_pend) begin
         w_disp_nxt = r_shadow;
      end
      w_hi_zero = 1'b1;
      for (int j = 0; j < int'(DIGITS); j++) begin
         if ((j >= int'(r_idx)) && (w_disp_nxt[4*j +: 4] != 4'd0)) begin
            w_hi_zero = 1'b0;
         end
      end
      // Blanking is decided once per slot so enables never glitch mid-slot
      w_blank = w_slot_start ? (bus.i_blz && (r_idx != '0) && w_hi_zero) : r_blank;
      w_nib   = w_disp_nxt[4*r_idx +: 4];
      w_an_on = ~(DIGITS'(1) << r_idx);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shadow <= '0;
         r_disp   <= '0;
         r_pend   <= 1'b0;
         r_blank  <= 1'b0;
         r_code   <= 4'd0;
         r_an     <= '1;
         r_frame  <= 1'b0;
      end else begin
         if (r_cnt == CW'(DIV - 1)) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
         r_disp <= w_disp_nxt;
         if (bus.i_load) begin
            r_shadow <= bus.i_din;
            r_pend   <= !w_bnd;
         end else if (w_bnd) begin
            r_pend   <= 1'b0;
         end
         r_blank <= w_blank;
         r_code  <= w_nib;
         r_an    <= ((r_cnt >= CW'(DEAD)) && !w_blank) ? w_an_on : '1;
         r_frame <= w_bnd;
      end
   end

   assign bus.o_code  = r_code;
   assign bus.o_an    = r_an;
   assign bus.o_pend  = r_pend;
   assign bus.o_frame = r_frame;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: per-cycle behavioural model built on absolute frame
// position, plus directed sequences with literal expected values.
module tb_seg_scan_ctrl;
   localparam int unsigned DIGITS = 4;
   localparam int unsigned DIV    = 8;
   localparam int unsigned DEAD   = 2;
   localparam int unsigned FRAMEP = DIGITS * DIV;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   pos;

   seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

   seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Model: outputs derived from frame position (0..FRAMEP-1) and the load rules
   initial begin : model
      int          np;
      logic        valid;
      logic [15:0] m_disp, m_shadow;
      logic        m_pend, m_blank;
      logic [3:0]  e_code;
      logic [3:0]  e_an;
      logic        e_frame, e_pend;
      int          slot, c, zeros;
      valid = 1'b0;
      np = 0; m_disp = '0; m_shadow = '0; m_pend = 0; m_blank = 0;
      e_code = 0; e_an = 4'hF; e_frame = 0; e_pend = 0;
      forever begin
         @(negedge clk);
         if (valid) begin
            chk("m_code",  32'(bus.o_code),  32'(e_code));
            chk("m_an",    32'(bus.o_an),    32'(e_an));
            chk("m_frame", 32'(bus.o_frame), 32'(e_frame));
            chk("m_pend",  32'(bus.o_pend),  32'(e_pend));
            zeros = $countones(~bus.o_an);
            chk("an_onehot", 32'(zeros <= 1), 32'd1);
         end
         if (rst) begin
            valid = 1'b1;
            np = 0; m_disp = '0; m_shadow = '0; m_pend = 0; m_blank = 0;
            e_code = 0; e_an = 4'hF; e_frame = 0; e_pend = 0;
         end else begin
            slot = np / int'(DIV);
            c    = np % int'(DIV);
            if (np == 0) begin
               if (bus.i_load) begin
                  m_disp = bus.i_din; m_shadow = bus.i_din; m_pend = 0;
               end else if (m_pend) begin
                  m_disp = m_shadow; m_pend = 0;
               end
            end else if (bus.i_load) begin
               m_shadow = bus.i_din; m_pend = 1;
            end
            if (c == 0) m_blank = bus.i_blz && (slot != 0) && ((m_disp >> (4*slot)) == 16'd0);
            e_frame = (np == 0);
            e_code  = 4'((m_disp >> (4*slot)) & 16'hF);
            e_an    = (c < int'(DEAD) || m_blank) ? 4'hF : ~(4'd1 << slot);
            e_pend  = m_pend;
            np = (np + 1) % int'(FRAMEP);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      pos = (pos + 1) % int'(FRAMEP);
   endtask

   task automatic go_to(input int p);
      for (int k = 0; k < int'(FRAMEP) && pos != p; k++) tick();
   endtask

   task automatic load_now(input logic [15:0] v);
      bus.i_load = 1'b1;
      bus.i_din  = v;
      tick();
      bus.i_load = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin : stim
      rst = 1'b1;
      bus.i_load = 1'b0;
      bus.i_din  = '0;
      bus.i_blz  = 1'b0;
      pos = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_an",    32'(bus.o_an),    32'hF);
      chk("rst_code",  32'(bus.o_code),  32'h0);
      chk("rst_pend",  32'(bus.o_pend),  32'h0);
      chk("rst_frame", 32'(bus.o_frame), 32'h0);
      rst = 1'b0;
      pos = int'(FRAMEP) - 1;

      tick();
      chk("first_frame", 32'(bus.o_frame), 32'h1);
      chk("first_an",    32'(bus.o_an),    32'hF);
      tick();
      chk("dead1_an",    32'(bus.o_an),    32'hF);
      chk("dead1_frame", 32'(bus.o_frame), 32'h0);
      tick();
      chk("slot0_an", 32'(bus.o_an), 32'hE);
      go_to(10); chk("slot1_an", 32'(bus.o_an), 32'hD);
      go_to(18); chk("slot2_an", 32'(bus.o_an), 32'hB);
      go_to(26); chk("slot3_an", 32'(bus.o_an), 32'h7);
      go_to(0);  chk("frame_period", 32'(bus.o_frame), 32'h1);

      go_to(11);
      load_now(16'h1234);
      chk("pend_rise",  32'(bus.o_pend), 32'h1);
      chk("code_held",  32'(bus.o_code), 32'h0);
      go_to(0);  chk("upd_pend", 32'(bus.o_pend), 32'h0);
                 chk("upd_c0",   32'(bus.o_code), 32'h4);
      go_to(8);  chk("upd_c1",   32'(bus.o_code), 32'h3);
      go_to(16); chk("upd_c2",   32'(bus.o_code), 32'h2);
      go_to(24); chk("upd_c3",   32'(bus.o_code), 32'h1);

      go_to(31);
      load_now(16'hBEEF);
      chk("bnd_pend", 32'(bus.o_pend),  32'h0);
      chk("bnd_code", 32'(bus.o_code),  32'hF);
      chk("bnd_frame",32'(bus.o_frame), 32'h1);
      go_to(5);
      load_now(16'h0001);
      chk("mid_pend", 32'(bus.o_pend), 32'h1);
      go_to(8);  chk("mid_old", 32'(bus.o_code), 32'hE);
      go_to(0);  chk("mid_new", 32'(bus.o_code), 32'h1);
                 chk("mid_pend_clr", 32'(bus.o_pend), 32'h0);

      bus.i_blz = 1'b1;
      go_to(31);
      load_now(16'h0050);
      go_to(2);  chk("blz_an0", 32'(bus.o_an), 32'hE);
      go_to(8);  chk("blz_c1",  32'(bus.o_code), 32'h5);
      go_to(10); chk("blz_an1", 32'(bus.o_an), 32'hD);
      go_to(16); chk("blz_c2",  32'(bus.o_code), 32'h0);
      go_to(18); chk("blz_an2", 32'(bus.o_an), 32'hF);
      go_to(26); chk("blz_an3", 32'(bus.o_an), 32'hF);

      go_to(31);
      load_now(16'h0000);
      go_to(2);  chk("zero_an0",  32'(bus.o_an),   32'hE);
                 chk("zero_code", 32'(bus.o_code), 32'h0);
      go_to(10); chk("zero_an1",  32'(bus.o_an),   32'hF);
      go_to(26); chk("zero_an3",  32'(bus.o_an),   32'hF);

      bus.i_blz = 1'b0;
      go_to(5);
      load_now(16'hABCD);
      go_to(20); chk("pre_rst_pend", 32'(bus.o_pend), 32'h1);
      rst = 1'b1;
      tick();
      chk("mrst_an",    32'(bus.o_an),    32'hF);
      chk("mrst_code",  32'(bus.o_code),  32'h0);
      chk("mrst_pend",  32'(bus.o_pend),  32'h0);
      chk("mrst_frame", 32'(bus.o_frame), 32'h0);
      rst = 1'b0;
      pos = int'(FRAMEP) - 1;
      tick();
      chk("mrst_first_frame", 32'(bus.o_frame), 32'h1);
      chk("mrst_first_code",  32'(bus.o_code),  32'h0);
      go_to(1);
      go_to(0);
      chk("discard_code", 32'(bus.o_code), 32'h0);
      chk("discard_pend", 32'(bus.o_pend), 32'h0);
      go_to(16);
      chk("discard_c2", 32'(bus.o_code), 32'h0);

      @(posedge clk);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
